parking_input_frontend: RTL

- Upstream conditioning stage for parking_system. It feeds the parking_system inputs sensor_entrance, sensor_exit, password_1 and password_2.
- Synchronises and debounces the raw entrance and exit car sensors.
- Assembles a two-digit keypad entry into the held password_1/password_2 pair, with a timeout, error flagging and a clear function.

---
 rtl/parking_input_frontend_pkg.sv | 14 +
 rtl/parking_input_frontend_debounce.sv | 49 ++++
 rtl/parking_input_frontend.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/parking_input_frontend_pkg.sv
// Shared types and constants for the parking input frontend.
// Keypad state encoding doubles as the digit count.
package parking_pkg;

    localparam int DIGIT_W     = 2;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } kp_state_t;

endpackage

// File: rtl/parking_input_frontend_debounce.sv
// Sensor conditioning: multi-flop synchroniser followed by a
// stability counter that only passes changes held long enough.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced == level_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
            level_d = synced;
            cnt_d   = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/parking_input_frontend.sv
// Front end for parking_system: debounced car sensors plus a
// two-digit keypad assembler with timeout, error and clear.
module parking_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int DIGIT_W         = parking_pkg::DIGIT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               raw_entrance,
    input  logic               raw_exit,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_enter,
    input  logic               key_clear,
    output logic               sensor_entrance,
    output logic               sensor_exit,
    output logic [DIGIT_W-1:0] password_1,
    output logic [DIGIT_W-1:0] password_2,
    output logic               pw_valid,
    output logic               key_error,
    output logic [1:0]         digits_entered
);

    import parking_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    kp_state_t          state_q, state_d;
    logic [DIGIT_W-1:0] buf1_q, buf1_d;
    logic [DIGIT_W-1:0] buf2_q, buf2_d;
    logic [DIGIT_W-1:0] pw1_q, pw1_d;
    logic [DIGIT_W-1:0] pw2_q, pw2_d;
    logic               pwv_q, pwv_d;
    logic               err_q, err_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_entrance (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .raw_i  (raw_entrance),
        .level_o(sensor_entrance)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .raw_i  (raw_exit),
        .level_o(sensor_exit)
    );

    assign password_1     = pw1_q;
    assign password_2     = pw2_q;
    assign pw_valid       = pwv_q;
    assign key_error      = err_q;
    assign digits_entered = state_q;

    always_comb begin
        state_d = state_q;
        buf1_d  = buf1_q;
        buf2_d  = buf2_q;
        pw1_d   = pw1_q;
        pw2_d   = pw2_q;
        pwv_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        if (key_clear) begin
            state_d = IDLE;
            buf1_d  = '0;
            buf2_d  = '0;
            pw1_d   = '0;
            pw2_d   = '0;
            tmo_d   = '0;
        end else if (key_valid && key_enter) begin
            err_d = 1'b1;
            tmo_d = '0;
        end else if (key_valid) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    buf1_d  = key_digit;
                    state_d = ONE;
                end
                ONE: begin
                    buf2_d  = key_digit;
                    state_d = TWO;
                end
                TWO:     err_d   = 1'b1;
                default: state_d = IDLE;
            endcase
        end else if (key_enter) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: err_d = 1'b1;
                ONE:  err_d = 1'b1;
                TWO: begin
                    pw1_d   = buf1_q;
                    pw2_d   = buf2_q;
                    pwv_d   = 1'b1;
                    buf1_d  = '0;
                    buf2_d  = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // abandoned partial entry: drop it, keep the held pair
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                buf1_d  = '0;
                buf2_d  = '0;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf1_q  <= '0;
            buf2_q  <= '0;
            pw1_q   <= '0;
            pw2_q   <= '0;
            pwv_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            buf1_q  <= buf1_d;
            buf2_q  <= buf2_d;
            pw1_q   <= pw1_d;
            pw2_q   <= pw2_d;
            pwv_q   <= pwv_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
